// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI bus arbiter: FSM state encoding,
// SPI mode bundle and small elaboration-time arithmetic.
package spi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        XFER,
        HOLD,
        GAP
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int CS_SETUP_DEFAULT = 4;
    localparam int CS_HOLD_DEFAULT  = 4;

    // Width of the shared setup/hold counter; never narrower than one bit.
    function automatic int cnt_width(input int setup, input int hold);
        int m;
        m = (setup > hold) ? setup : hold;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr.sv
// Round-robin requester select: combinational pick of the first request at or
// after the pointer, pointer advances past the owner when a burst completes.
module spi_rr_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    input  logic [IDX_W-1:0]   owner,
    output logic               any,
    output logic [NUM_REQ-1:0] sel,
    output logic [IDX_W-1:0]   sel_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int idx;
        any     = 1'b0;
        sel     = '0;
        sel_idx = '0;
        idx     = int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[idx]) begin
                any      = 1'b1;
                sel[idx] = 1'b1;
                sel_idx  = IDX_W'(idx);
            end
            idx = wrap_inc(idx, NUM_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (done) begin
            ptr <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI master between NUM_REQ requesters: grants a whole burst under
// one chip select, sequences byte start/done and enforces CS setup/hold time.
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CS_SETUP = CS_SETUP_DEFAULT,
    parameter int CS_HOLD  = CS_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [8*NUM_REQ-1:0] req_tx_data,
    input  logic [NUM_REQ-1:0]   req_cpol,
    input  logic [NUM_REQ-1:0]   req_cpha,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   tx_ack,
    output logic [NUM_REQ-1:0]   rx_valid,
    output logic [7:0]           rx_data,
    output logic [NUM_REQ-1:0]   cs_n,
    output logic                 m_start,
    output logic [7:0]           m_tx_data,
    output logic                 m_cpol,
    output logic                 m_cpha,
    input  logic [7:0]           m_rx_data,
    input  logic                 m_done,
    input  logic                 m_ready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(CS_SETUP, CS_HOLD);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] owner;
    logic             last;
    spi_mode_t        mode;

    logic               arb_any;
    logic [NUM_REQ-1:0] arb_sel;
    logic [IDX_W-1:0]   arb_idx;
    logic               hold_done;

    assign hold_done = (state == HOLD) && (int'(cnt) + 1 >= CS_HOLD);
    assign m_cpol    = mode.cpol;
    assign m_cpha    = mode.cpha;

    spi_rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (hold_done),
        .owner  (owner),
        .any    (arb_any),
        .sel    (arb_sel),
        .sel_idx(arb_idx)
    );

    // The mode is latched only at grant, so requester mode changes mid-burst
    // cannot disturb a transfer already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= '0;
            last      <= 1'b0;
            mode      <= '0;
            gnt       <= '0;
            cs_n      <= '1;
            tx_ack    <= '0;
            rx_valid  <= '0;
            rx_data   <= '0;
            m_start   <= 1'b0;
            m_tx_data <= '0;
        end else begin
            tx_ack   <= '0;
            rx_valid <= '0;
            m_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        owner <= arb_idx;
                        gnt   <= arb_sel;
                        cs_n  <= ~arb_sel;
                        mode  <= '{cpol: req_cpol[arb_idx], cpha: req_cpha[arb_idx]};
                        cnt   <= '0;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (int'(cnt) + 1 >= CS_SETUP) begin
                        cnt   <= '0;
                        state <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOAD: begin
                    if (m_ready && req[owner]) begin
                        m_start       <= 1'b1;
                        tx_ack[owner] <= 1'b1;
                        m_tx_data     <= req_tx_data[int'(owner)*8 +: 8];
                        last          <= req_last[owner];
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (m_done) begin
                        rx_data         <= m_rx_data;
                        rx_valid[owner] <= 1'b1;
                        cnt             <= '0;
                        state           <= last ? HOLD : LOAD;
                    end
                end
                HOLD: begin
                    if (hold_done) begin
                        gnt   <= '0;
                        cs_n  <= '1;
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: randomized bursts from several
// requesters against a round-robin burst-level reference model.
module tb_spi_bus_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int CS_SETUP  = 4;
    localparam int CS_HOLD   = 3;
    localparam int MAX_BYTES = 4;
    localparam int TIMEOUT   = 3000;

    typedef struct packed {
        logic [7:0] owner;
        logic [1:0] mode;
    } gnt_exp_t;

    typedef struct packed {
        logic [7:0] owner;
        logic [7:0] data;
        logic       last;
    } rx_exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [NUM_REQ-1:0]   req_last = '0;
    logic [8*NUM_REQ-1:0] req_tx_data = '0;
    logic [NUM_REQ-1:0]   req_cpol = '0;
    logic [NUM_REQ-1:0]   req_cpha = '0;
    logic [NUM_REQ-1:0]   gnt, tx_ack, rx_valid, cs_n;
    logic [7:0]           rx_data, m_tx_data;
    logic [7:0]           m_rx_data = '0;
    logic                 m_start, m_cpol, m_cpha;
    logic                 m_done = 1'b0;
    logic                 m_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;
    int cyc = 0;

    gnt_exp_t grant_q[$];
    rx_exp_t  rx_q[$];

    logic [7:0] bdata[NUM_REQ][MAX_BYTES];
    int         blen[NUM_REQ];
    logic [1:0] bmode[NUM_REQ];
    int         model_ptr = 0;

    localparam logic [NUM_REQ-1:0] ALL_ONES = {NUM_REQ{1'b1}};

    spi_bus_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_last   (req_last),
        .req_tx_data(req_tx_data),
        .req_cpol   (req_cpol),
        .req_cpha   (req_cpha),
        .gnt        (gnt),
        .tx_ack     (tx_ack),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .cs_n       (cs_n),
        .m_start    (m_start),
        .m_tx_data  (m_tx_data),
        .m_cpol     (m_cpol),
        .m_cpha     (m_cpha),
        .m_rx_data  (m_rx_data),
        .m_done     (m_done),
        .m_ready    (m_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s timed out at cycle %0d", name, cyc);
    endtask

    // Loopback SPI master: echoes each byte after a random latency and
    // occasionally emits a stray m_done while no transfer is in flight.
    initial begin
        int lat;
        bit busy;
        logic [7:0] held;
        lat = 0;
        busy = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (!rst) begin
                busy    = 1'b0;
                m_ready = 1'b1;
            end else if (busy) begin
                if (lat <= 1) begin
                    m_done    = 1'b1;
                    m_rx_data = held;
                    busy      = 1'b0;
                    m_ready   = 1'b1;
                end else begin
                    lat--;
                end
            end else if (m_start) begin
                busy    = 1'b1;
                m_ready = 1'b0;
                held    = m_tx_data;
                lat     = $urandom_range(1, 4);
            end else if ($urandom_range(0, 7) == 0) begin
                m_done    = 1'b1;
                m_rx_data = 8'($urandom);
            end
        end
    end

    // Monitor: pops expected grants and received bytes as the DUT shows them.
    initial begin
        logic [NUM_REQ-1:0] prev_gnt;
        logic [NUM_REQ-1:0] ngnt;
        logic [1:0] cur_mode;
        int gnt_cyc, last_rx_cyc;
        bit first_start;
        gnt_exp_t ge;
        rx_exp_t re;
        prev_gnt = '0;
        cur_mode = '0;
        gnt_cyc = 0;
        last_rx_cyc = 0;
        first_start = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                ngnt = ~gnt;
                checkOutput("cs_matches_gnt", 32'(cs_n), 32'(ngnt));
                checkOutput("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
                if (gnt !== '0 && prev_gnt === '0) begin
                    if (grant_q.size() == 0) begin
                        reportTimeout("unexpected_grant");
                    end else begin
                        ge = grant_q.pop_front();
                        checkOutput("gnt_owner", 32'(gnt), 32'(1) << ge.owner);
                        checkOutput("gnt_mode", 32'({m_cpol, m_cpha}), 32'(ge.mode));
                        cur_mode = ge.mode;
                        gnt_cyc = cyc;
                        first_start = 1'b1;
                    end
                end
                if (m_start) begin
                    checkOutput("ack_with_start", 32'(tx_ack), 32'(gnt));
                    checkOutput("start_mode", 32'({m_cpol, m_cpha}), 32'(cur_mode));
                    if (first_start) begin
                        checkOutput("setup_latency", 32'(cyc - gnt_cyc), 32'(CS_SETUP + 1));
                        first_start = 1'b0;
                    end
                end else if (tx_ack !== '0) begin
                    checkOutput("ack_without_start", 32'(tx_ack), 32'd0);
                end
                if (rx_valid !== '0) begin
                    if (rx_q.size() == 0) begin
                        reportTimeout("unexpected_rx_valid");
                    end else begin
                        re = rx_q.pop_front();
                        checkOutput("rx_owner", 32'(rx_valid), 32'(1) << re.owner);
                        checkOutput("rx_data", 32'(rx_data), 32'(re.data));
                        if (re.last) last_rx_cyc = cyc;
                    end
                end
                if (gnt === '0 && prev_gnt !== '0) begin
                    checkOutput("hold_latency", 32'(cyc - last_rx_cyc), 32'(CS_HOLD));
                end
            end
            prev_gnt = gnt;
        end
    end

    // One requester's burst: offer each byte until acked, maybe stall, and
    // scramble its mode inputs after the grant to prove they are ignored.
    task automatic drive(input int id);
        int waited;
        req_cpol[id] = bmode[id][1];
        req_cpha[id] = bmode[id][0];
        for (int b = 0; b < blen[id]; b++) begin
            req_tx_data[id*8 +: 8] = bdata[id][b];
            req_last[id] = (b == blen[id] - 1);
            req[id] = 1'b1;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!tx_ack[id] && waited < TIMEOUT);
            if (!tx_ack[id]) begin
                reportTimeout("tx_ack_wait");
                req[id] = 1'b0;
                return;
            end
            req[id] = 1'b0;
            if (b == 0) begin
                req_cpol[id] = 1'($urandom_range(0, 1));
                req_cpha[id] = 1'($urandom_range(0, 1));
            end
            if (b < blen[id] - 1 && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 10)) @(negedge clk);
            end
        end
        req_last[id] = 1'b0;
    endtask

    // Burst-level reference: all masked requesters are pending together, so
    // service order is the cyclic order starting at the model pointer.
    task automatic applyStimulus(input logic [NUM_REQ-1:0] mask);
        int last_served;
        int idle_run;
        int waited;
        last_served = model_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (model_ptr + k) % NUM_REQ;
            if (mask[i]) begin
                grant_q.push_back('{owner: 8'(i), mode: bmode[i]});
                for (int b = 0; b < blen[i]; b++) begin
                    rx_q.push_back('{owner: 8'(i), data: bdata[i][b], last: (b == blen[i] - 1)});
                end
                last_served = i;
            end
        end
        model_ptr = (last_served + 1) % NUM_REQ;
        @(negedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                automatic int id = i;
                fork
                    drive(id);
                join_none
            end
        end
        wait fork;
        idle_run = 0;
        waited = 0;
        while (idle_run < 3 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
            if (cs_n === ALL_ONES) idle_run++;
            else idle_run = 0;
        end
        if (idle_run < 3) reportTimeout("bus_idle_wait");
    endtask

    task automatic randomBurst(input int i);
        blen[i] = $urandom_range(1, MAX_BYTES);
        bmode[i] = 2'($urandom_range(0, 3));
        for (int b = 0; b < MAX_BYTES; b++) bdata[i][b] = 8'($urandom);
    endtask

    initial begin
        int acks;
        int waited;
        repeat (3) @(negedge clk);
        checkOutput("reset_cs_n", 32'(cs_n), 32'(ALL_ONES));
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_m_start", 32'(m_start), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_mode", 32'({m_cpol, m_cpha}), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        blen[0] = 1; bdata[0][0] = 8'hAA; bmode[0] = 2'b00;
        applyStimulus(NUM_REQ'(1));
        blen[1] = 3; bdata[1][0] = 8'h11; bdata[1][1] = 8'h22; bdata[1][2] = 8'h33; bmode[1] = 2'b10;
        applyStimulus(NUM_REQ'(2));
        repeat (2) begin
            randomBurst(0); randomBurst(1);
            blen[0] = 1; blen[1] = 1;
            applyStimulus(NUM_REQ'(3));
        end
        repeat (30) begin
            for (int i = 0; i < NUM_REQ; i++) randomBurst(i);
            applyStimulus(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)));
        end
        randomBurst(0);
        applyStimulus(NUM_REQ'(1));

        mon_en = 1'b0;
        req_cpol[1] = 1'b0;
        req_cpha[1] = 1'b1;
        req_tx_data[15:8] = 8'h3C;
        req_last[1] = 1'b0;
        req[1] = 1'b1;
        acks = 0;
        waited = 0;
        while (acks < 2 && waited < TIMEOUT) begin
            @(negedge clk);
            waited++;
            if (tx_ack[1]) acks++;
        end
        if (acks < 2) reportTimeout("abort_burst_ack");
        rst = 1'b0;
        #1;
        checkOutput("abort_cs_n", 32'(cs_n), 32'(ALL_ONES));
        checkOutput("abort_gnt", 32'(gnt), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);
        checkOutput("abort_mode", 32'({m_cpol, m_cpha}), 32'd0);
        checkOutput("abort_rx_valid", 32'(rx_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        model_ptr = 0;
        grant_q.delete();
        rx_q.delete();
        mon_en = 1'b1;
        randomBurst(0); randomBurst(1);
        applyStimulus(NUM_REQ'(3));

        checkOutput("grant_q_drained", 32'(grant_q.size()), 32'd0);
        checkOutput("rx_q_drained", 32'(rx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
